// File: rtl/ctrl_seq_unit.sv
// Registered control sequencer: decodes opcodes into execute-stage enables and
// sequences reset boot, two-word immediates, halt, stalls and illegal opcodes.
module ctrl_seq_unit #(
    parameter int OPC_W       = 7,
    parameter int BOOT_CYCLES = 2,
    parameter int ALU_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             instr_valid,
    input  logic             stall,
    output logic [ALU_W-1:0] alu_op,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             imm_sel,
    output logic             out_en,
    output logic             in_en,
    output logic             pc_en,
    output logic             pc_rst_load,
    output logic             fetch_imm,
    output logic             halted,
    output logic             illegal,
    output logic             boot
);

    typedef enum logic [2:0] {RST, BOOT, RUN, IMM, HALT} state_t;
    typedef enum logic [1:0] {P_IADD, P_LDM, P_LDD, P_STD} pend_t;

    state_t state, state_nxt;
    pend_t  pend, d_pend;
    logic [3:0] cnt;

    logic [6:0]       op7;
    logic             op_hi_ok;
    logic [ALU_W-1:0] d_alu;
    logic             d_rw, d_oe, d_ie, d_two, d_hlt, d_ill;
    logic             take;

    logic [ALU_W-1:0] n_alu;
    logic n_rw, n_mr, n_mw, n_is, n_oe, n_ie;
    logic n_pc, n_prl, n_fi, n_halt, n_ill, n_boot;

    assign op7      = opcode[6:0];
    assign op_hi_ok = (opcode >> 7) == '0;
    assign take     = (state == RUN) && !stall && instr_valid;

    // Opcode decode; any nonzero bit above the 7-bit field makes it unknown.
    always_comb begin
        d_alu  = '0;
        d_rw   = 1'b0;
        d_oe   = 1'b0;
        d_ie   = 1'b0;
        d_two  = 1'b0;
        d_hlt  = 1'b0;
        d_ill  = 1'b0;
        d_pend = P_IADD;
        case (op7)
            7'b0010001: begin d_alu = ALU_W'(4); d_rw = 1'b1; end
            7'b0000011: begin d_alu = ALU_W'(5); d_rw = 1'b1; end
            7'b0010101: d_rw = 1'b1;
            7'b0000001: begin d_alu = ALU_W'(1); d_rw = 1'b1; end
            7'b0001001: begin d_alu = ALU_W'(2); d_rw = 1'b1; end
            7'b0001101: begin d_alu = ALU_W'(3); d_rw = 1'b1; end
            7'b0011001: d_oe = 1'b1;
            7'b0011000: begin d_ie = 1'b1; d_rw = 1'b1; end
            7'b1100010: d_alu = ALU_W'(6);
            7'b1101000: ;
            7'b1100001: d_hlt = 1'b1;
            7'b0100000: d_two = 1'b1;
            7'b0110101: begin d_two = 1'b1; d_pend = P_LDM; end
            7'b0100010: begin d_two = 1'b1; d_pend = P_LDD; end
            7'b0100011: begin d_two = 1'b1; d_pend = P_STD; end
            default:    d_ill = 1'b1;
        endcase
        if (!op_hi_ok) begin
            d_alu = '0;
            d_rw  = 1'b0;
            d_oe  = 1'b0;
            d_ie  = 1'b0;
            d_two = 1'b0;
            d_hlt = 1'b0;
            d_ill = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
            cnt   <= 4'(BOOT_CYCLES - 1);
            pend  <= P_IADD;
        end else begin
            state <= state_nxt;
            if (state == BOOT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (take && d_two)
                pend <= d_pend;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST:  state_nxt = BOOT;
            BOOT: if (cnt == 4'd0) state_nxt = RUN;
            RUN: begin
                if (take && d_hlt)      state_nxt = HALT;
                else if (take && d_two) state_nxt = IMM;
            end
            IMM:  if (!stall && instr_valid) state_nxt = RUN;
            HALT: state_nxt = HALT;
            default: state_nxt = RST;
        endcase
    end

    // Next registered output values; everything not set below is a bubble.
    always_comb begin
        n_alu  = '0;
        n_rw   = 1'b0;
        n_mr   = 1'b0;
        n_mw   = 1'b0;
        n_is   = 1'b0;
        n_oe   = 1'b0;
        n_ie   = 1'b0;
        n_pc   = 1'b0;
        n_prl  = 1'b0;
        n_fi   = 1'b0;
        n_halt = 1'b0;
        n_ill  = 1'b0;
        n_boot = 1'b0;
        if (reset) begin
            n_prl  = 1'b1;
            n_boot = 1'b1;
        end else begin
            case (state)
                RST: begin
                    n_pc   = 1'b1;
                    n_boot = 1'b1;
                end
                BOOT: begin
                    n_pc   = 1'b1;
                    n_boot = cnt != 4'd0;
                end
                RUN: begin
                    if (!stall && !instr_valid) begin
                        n_pc = 1'b1;
                    end else if (take) begin
                        n_pc   = !d_hlt;
                        n_halt = d_hlt;
                        n_alu  = d_alu;
                        n_rw   = d_rw;
                        n_oe   = d_oe;
                        n_ie   = d_ie;
                        n_fi   = d_two;
                        n_ill  = d_ill;
                    end
                end
                IMM: begin
                    if (!stall && instr_valid) begin
                        n_pc  = 1'b1;
                        n_is  = 1'b1;
                        n_alu = (pend == P_LDM) ? ALU_W'(0) : ALU_W'(1);
                        n_rw  = pend != P_STD;
                        n_mr  = pend == P_LDD;
                        n_mw  = pend == P_STD;
                    end
                end
                HALT: n_halt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        alu_op      <= n_alu;
        reg_write   <= n_rw;
        mem_read    <= n_mr;
        mem_write   <= n_mw;
        imm_sel     <= n_is;
        out_en      <= n_oe;
        in_en       <= n_ie;
        pc_en       <= n_pc;
        pc_rst_load <= n_prl;
        fetch_imm   <= n_fi;
        halted      <= n_halt;
        illegal     <= n_ill;
        boot        <= n_boot;
    end

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Directed scoreboard bench for ctrl_seq_unit: each step pushes the expected
// output word and compares it one clock later.
module tb_ctrl_seq_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       instr_valid = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] alu_op;
    logic reg_write, mem_read, mem_write, imm_sel, out_en, in_en;
    logic pc_en, pc_rst_load, fetch_imm, halted, illegal, boot;

    ctrl_seq_unit #(.OPC_W(7), .BOOT_CYCLES(2), .ALU_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .instr_valid(instr_valid), .stall(stall),
        .alu_op(alu_op), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .imm_sel(imm_sel), .out_en(out_en),
        .in_en(in_en), .pc_en(pc_en), .pc_rst_load(pc_rst_load),
        .fetch_imm(fetch_imm), .halted(halted), .illegal(illegal),
        .boot(boot)
    );

    always #5 clk = ~clk;

    localparam logic [15:0] RW  = 16'h0800, MR = 16'h0400, MW = 16'h0200;
    localparam logic [15:0] IS  = 16'h0100, OE = 16'h0080, IE = 16'h0040;
    localparam logic [15:0] PC  = 16'h0020, PRL = 16'h0010, FI = 16'h0008;
    localparam logic [15:0] HL  = 16'h0004, IL = 16'h0002, BT = 16'h0001;
    localparam logic [15:0] BUB = 16'h0000;

    localparam logic [6:0] NOT_ = 7'b0010001, INC = 7'b0000011;
    localparam logic [6:0] MOV = 7'b0010101, ADD = 7'b0000001;
    localparam logic [6:0] SUB = 7'b0001001, AND_ = 7'b0001101;
    localparam logic [6:0] OUT = 7'b0011001, IN_ = 7'b0011000;
    localparam logic [6:0] SETC = 7'b1100010, NOP = 7'b1101000;
    localparam logic [6:0] HLT = 7'b1100001, IADD = 7'b0100000;
    localparam logic [6:0] LDM = 7'b0110101, LDD = 7'b0100010;
    localparam logic [6:0] STD = 7'b0100011;

    logic [15:0] sb[$];
    int checks = 0;
    int passes = 0;

    function automatic logic [15:0] A(input int n);
        return 16'(n) << 12;
    endfunction

    task automatic step(input logic r, input logic v, input logic s,
                        input logic [6:0] op, input logic [15:0] e,
                        input string tag);
        logic [15:0] got, want;
        @(negedge clk);
        reset = r;
        instr_valid = v;
        stall = s;
        opcode = op;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {alu_op, reg_write, mem_read, mem_write, imm_sel, out_en,
               in_en, pc_en, pc_rst_load, fetch_imm, halted, illegal, boot};
        want = sb.pop_front();
        checks++;
        assert (got === want) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, got, want);
    endtask

    initial begin
        step(1, 0, 0, NOP, PRL | BT, "rst0");
        step(1, 1, 0, ADD, PRL | BT, "rst1");
        step(1, 0, 1, ADD, PRL | BT, "rst2");
        step(0, 1, 0, ADD, PC | BT, "boot0");
        step(0, 1, 1, ADD, PC | BT, "boot1");
        step(0, 0, 0, NOP, PC, "boot_exit");
        step(0, 1, 0, ADD, A(1) | RW | PC, "add");

        step(0, 1, 0, LDD, FI | PC, "ldd_op");
        step(0, 1, 0, 7'h7F, A(1) | IS | MR | RW | PC, "ldd_imm");
        step(0, 1, 0, NOP, PC, "nop");

        step(0, 1, 0, STD, FI | PC, "std_op");
        step(0, 1, 1, ADD, BUB, "std_stall0");
        step(0, 1, 1, ADD, BUB, "std_stall1");
        step(0, 0, 0, ADD, BUB, "std_wait");
        step(0, 1, 0, 7'h12, A(1) | IS | MW | PC, "std_imm");
        step(0, 0, 0, STD, PC, "std_once");

        step(0, 1, 0, NOT_, A(4) | RW | PC, "not");
        step(0, 1, 0, INC, A(5) | RW | PC, "inc");
        step(0, 1, 0, MOV, RW | PC, "mov");
        step(0, 1, 0, AND_, A(3) | RW | PC, "and");
        step(0, 1, 0, OUT, OE | PC, "out");
        step(0, 1, 0, IN_, IE | RW | PC, "in");
        step(0, 1, 0, SETC, A(6) | PC, "setc");
        step(0, 1, 1, ADD, BUB, "run_stall");

        step(0, 1, 0, 7'h7F, IL | PC, "illegal");
        step(0, 1, 0, SUB, A(2) | RW | PC, "sub");

        step(0, 1, 0, LDM, FI | PC, "ldm_op");
        step(0, 1, 0, 7'h55, IS | RW | PC, "ldm_imm");

        step(0, 1, 0, IADD, FI | PC, "iadd_op");
        step(1, 1, 0, 7'h01, PRL | BT, "iadd_rst");
        step(0, 1, 0, ADD, PC | BT, "reboot0");
        step(0, 1, 0, ADD, PC | BT, "reboot1");
        step(0, 1, 0, ADD, PC, "reboot_exit");
        step(0, 1, 0, ADD, A(1) | RW | PC, "add2");

        step(0, 1, 0, HLT, HL, "hlt");
        for (int i = 0; i < 10; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 7'($urandom_range(0, 127)), HL, "halted");
        step(1, 0, 0, NOP, PRL | BT, "halt_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
